// File: rtl/ps2_key_decoder_if.sv
// Byte-stream and character-FIFO signals between a PS/2 receiver/terminal side
// (master) and the scan-code decoder (slave).
interface ps2_key_decoder_if;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       key_rd;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       shift_st;
    logic       ctrl_st;
    logic       caps_st;
    logic       overflow;

    modport master (
        output scan_data, scan_valid, key_rd,
        input  key_ascii, key_valid, shift_st, ctrl_st, caps_st, overflow
    );

    modport slave (
        input  scan_data, scan_valid, key_rd,
        output key_ascii, key_valid, shift_st, ctrl_st, caps_st, overflow
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser, modifier tracker and ASCII FIFO.
// Define PS2_EXT_KEYS_EN to translate cursor/navigation keys to codes 7Fh..85h.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    ps2_key_decoder_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    // Lower-case letter for a normal make code; bit 8 flags a hit.
    function automatic logic [8:0] letter_lc(input logic [7:0] c);
        case (c)
            8'h1C: return {1'b1, 8'h61};
            8'h32: return {1'b1, 8'h62};
            8'h21: return {1'b1, 8'h63};
            8'h23: return {1'b1, 8'h64};
            8'h24: return {1'b1, 8'h65};
            8'h2B: return {1'b1, 8'h66};
            8'h34: return {1'b1, 8'h67};
            8'h33: return {1'b1, 8'h68};
            8'h43: return {1'b1, 8'h69};
            8'h3B: return {1'b1, 8'h6A};
            8'h42: return {1'b1, 8'h6B};
            8'h4B: return {1'b1, 8'h6C};
            8'h3A: return {1'b1, 8'h6D};
            8'h31: return {1'b1, 8'h6E};
            8'h44: return {1'b1, 8'h6F};
            8'h4D: return {1'b1, 8'h70};
            8'h15: return {1'b1, 8'h71};
            8'h2D: return {1'b1, 8'h72};
            8'h1B: return {1'b1, 8'h73};
            8'h2C: return {1'b1, 8'h74};
            8'h3C: return {1'b1, 8'h75};
            8'h2A: return {1'b1, 8'h76};
            8'h1D: return {1'b1, 8'h77};
            8'h22: return {1'b1, 8'h78};
            8'h35: return {1'b1, 8'h79};
            8'h1A: return {1'b1, 8'h7A};
            default: return 9'h000;
        endcase
    endfunction

    // Digits, punctuation and fixed control keys; only Shift affects them.
    function automatic logic [8:0] symbol_map(input logic [7:0] c, input logic shift);
        case (c)
            8'h16: return {1'b1, shift ? 8'h21 : 8'h31};
            8'h1E: return {1'b1, shift ? 8'h40 : 8'h32};
            8'h26: return {1'b1, shift ? 8'h23 : 8'h33};
            8'h25: return {1'b1, shift ? 8'h24 : 8'h34};
            8'h2E: return {1'b1, shift ? 8'h25 : 8'h35};
            8'h36: return {1'b1, shift ? 8'h5E : 8'h36};
            8'h3D: return {1'b1, shift ? 8'h26 : 8'h37};
            8'h3E: return {1'b1, shift ? 8'h2A : 8'h38};
            8'h46: return {1'b1, shift ? 8'h28 : 8'h39};
            8'h45: return {1'b1, shift ? 8'h29 : 8'h30};
            8'h4E: return {1'b1, shift ? 8'h5F : 8'h2D};
            8'h55: return {1'b1, shift ? 8'h2B : 8'h3D};
            8'h54: return {1'b1, shift ? 8'h7B : 8'h5B};
            8'h5B: return {1'b1, shift ? 8'h7D : 8'h5D};
            8'h4C: return {1'b1, shift ? 8'h3A : 8'h3B};
            8'h52: return {1'b1, shift ? 8'h22 : 8'h27};
            8'h0E: return {1'b1, shift ? 8'h7E : 8'h60};
            8'h41: return {1'b1, shift ? 8'h3C : 8'h2C};
            8'h49: return {1'b1, shift ? 8'h3E : 8'h2E};
            8'h4A: return {1'b1, shift ? 8'h3F : 8'h2F};
            8'h5D: return {1'b1, shift ? 8'h7C : 8'h5C};
            8'h29: return {1'b1, 8'h20};
            8'h5A: return {1'b1, 8'h0D};
            8'h66: return {1'b1, 8'h08};
            8'h0D: return {1'b1, 8'h09};
            8'h76: return {1'b1, 8'h1B};
            default: return 9'h000;
        endcase
    endfunction

`ifdef PS2_EXT_KEYS_EN
    function automatic logic [8:0] ext_map(input logic [7:0] c);
        case (c)
            8'h75: return {1'b1, 8'h80};
            8'h72: return {1'b1, 8'h81};
            8'h6B: return {1'b1, 8'h82};
            8'h74: return {1'b1, 8'h83};
            8'h6C: return {1'b1, 8'h84};
            8'h69: return {1'b1, 8'h85};
            8'h71: return {1'b1, 8'h7F};
            default: return 9'h000;
        endcase
    endfunction
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_ignore;
    logic            w_evt;
    logic            w_evt_brk;
    logic            w_evt_ext;

    logic            r_lshift, r_rshift, r_lctrl, r_rctrl;
    logic            r_caps, r_caps_held;
    logic            w_shift, w_ctrl;
    logic            w_is_lshift, w_is_rshift, w_is_lctrl, w_is_rctrl, w_is_caps, w_is_mod;

    logic [8:0]      w_letter;
    logic [8:0]      w_symbol;
    logic            w_hit;
    logic [7:0]      w_char;
    logic            w_push;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            w_full, w_empty, w_pop, w_wr_en;

    // Status/ack bytes from the keyboard carry no key information.
    assign w_ignore = (bus.scan_data == 8'hAA) || (bus.scan_data == 8'hFA) ||
                      (bus.scan_data == 8'hEE) || (bus.scan_data == 8'hFE) ||
                      (bus.scan_data == 8'h00) || (bus.scan_data == 8'hFF);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_evt_brk   = 1'b0;
        w_evt_ext   = 1'b0;
        if (bus.scan_valid && !w_ignore) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scan_data == 8'hF0)      w_state_nxt = ST_BRK;
                    else if (bus.scan_data == 8'hE0) w_state_nxt = ST_EXT;
                    else                             w_evt = 1'b1;
                end
                ST_BRK: begin
                    w_evt       = 1'b1;
                    w_evt_brk   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    if (bus.scan_data == 8'hF0)      w_state_nxt = ST_EXT_BRK;
                    else if (bus.scan_data == 8'hE0) w_state_nxt = ST_EXT;
                    else begin
                        w_evt       = 1'b1;
                        w_evt_ext   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    w_evt       = 1'b1;
                    w_evt_brk   = 1'b1;
                    w_evt_ext   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_is_lshift = !w_evt_ext && (bus.scan_data == 8'h12);
    assign w_is_rshift = !w_evt_ext && (bus.scan_data == 8'h59);
    assign w_is_lctrl  = !w_evt_ext && (bus.scan_data == 8'h14);
    assign w_is_rctrl  =  w_evt_ext && (bus.scan_data == 8'h14);
    assign w_is_caps   = !w_evt_ext && (bus.scan_data == 8'h58);
    assign w_is_mod    = w_is_lshift | w_is_rshift | w_is_lctrl | w_is_rctrl | w_is_caps;

    assign w_shift = r_lshift | r_rshift;
    assign w_ctrl  = r_lctrl | r_rctrl;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_evt) begin
            if (w_is_lshift) r_lshift <= !w_evt_brk;
            if (w_is_rshift) r_rshift <= !w_evt_brk;
            if (w_is_lctrl)  r_lctrl  <= !w_evt_brk;
            if (w_is_rctrl)  r_rctrl  <= !w_evt_brk;
            if (w_is_caps) begin
                if (w_evt_brk) begin
                    r_caps_held <= 1'b0;
                end else begin
                    // Typematic repeats arrive with caps_held set and leave the toggle alone.
                    if (!r_caps_held) r_caps <= ~r_caps;
                    r_caps_held <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_letter = letter_lc(bus.scan_data);
        w_symbol = symbol_map(bus.scan_data, w_shift);
        w_hit    = 1'b0;
        w_char   = 8'h00;
        if (w_evt_ext) begin
`ifdef PS2_EXT_KEYS_EN
            {w_hit, w_char} = ext_map(bus.scan_data);
`endif
        end else if (w_letter[8]) begin
            w_hit = 1'b1;
            if (w_ctrl)                 w_char = w_letter[7:0] & 8'h1F;
            else if (w_shift ^ r_caps)  w_char = w_letter[7:0] & 8'hDF;
            else                        w_char = w_letter[7:0];
        end else if (w_symbol[8]) begin
            w_hit  = 1'b1;
            w_char = w_symbol[7:0];
        end
        w_push = w_evt && !w_evt_brk && !w_is_mod && w_hit;
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = bus.key_rd && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the reset count masks stale entries from key_ascii.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_char;
    end

    assign bus.key_valid = !w_empty;
    assign bus.key_ascii = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.shift_st  = w_shift;
    assign bus.ctrl_st   = w_ctrl;
    assign bus.caps_st   = r_caps;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed scoreboard bench for ps2_key_decoder (FIFO_DEPTH=8); honours PS2_EXT_KEYS_EN.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte with a one-cycle strobe; returns on the negedge after capture.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.scan_data  = b;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask

    task automatic make(input logic [7:0] code, input logic [7:0] ch);
        send(code);
        exp_q.push_back(ch);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        int waited;
        waited = 0;
        e = exp_q.pop_front();
        while (bus.key_valid !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 8'(bus.key_valid), 8'h01);
        check(tag, bus.key_ascii, e);
        bus.key_rd = 1'b1;
        @(negedge clk);
        bus.key_rd = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_valid"}, 8'(bus.key_valid), 8'h00);
        check({tag, "_ascii"}, bus.key_ascii, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.scan_data  = 8'h00;
        bus.scan_valid = 1'b0;
        bus.key_rd     = 1'b0;
        #22;
        expect_empty("reset");
        check("reset_shift", 8'(bus.shift_st), 8'h00);
        check("reset_ctrl",  8'(bus.ctrl_st),  8'h00);
        check("reset_caps",  8'(bus.caps_st),  8'h00);
        check("reset_ovf",   8'(bus.overflow), 8'h00);
        @(negedge clk);
        clr_n = 1'b1;

        // Make/break of 'a': one entry, visible the cycle after the make.
        make(8'h1C, 8'h61);
        check("first_push_latency", 8'(bus.key_valid), 8'h01);
        send(8'hF0);
        send(8'h1C);
        pop_check("a_single");
        expect_empty("a_after_pop");

        // Shifted letter and digit, then release.
        send(8'h12);
        check("shift_held", 8'(bus.shift_st), 8'h01);
        make(8'h1C, 8'h41);
        make(8'h16, 8'h21);
        send(8'hF0);
        send(8'h12);
        check("shift_released", 8'(bus.shift_st), 8'h00);
        make(8'h1C, 8'h61);
        pop_check("shift_A");
        pop_check("shift_bang");
        pop_check("plain_a");
        expect_empty("shift_drained");

        // Punctuation pair via right Shift.
        send(8'h59);
        make(8'h4E, 8'h5F);
        send(8'hF0);
        send(8'h59);
        make(8'h4E, 8'h2D);
        pop_check("underscore");
        pop_check("minus");

        // Caps Lock with a typematic repeat toggles once.
        send(8'h58);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check("caps_on", 8'(bus.caps_st), 8'h01);
        make(8'h1C, 8'h41);
        pop_check("caps_A");
        send(8'h12);
        make(8'h1C, 8'h61);
        send(8'hF0);
        send(8'h12);
        pop_check("caps_shift_a");
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check("caps_off", 8'(bus.caps_st), 8'h00);

        // Status byte between break prefix and code is skipped; still a break.
        send(8'hF0);
        send(8'hAA);
        send(8'h1C);
        expect_empty("ignored_byte_break");

        // Right Ctrl overrides Shift for letters.
        send(8'hE0);
        send(8'h14);
        check("ctrl_held", 8'(bus.ctrl_st), 8'h01);
        make(8'h21, 8'h03);
        send(8'h12);
        make(8'h1C, 8'h01);
        send(8'hF0);
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h14);
        check("ctrl_released", 8'(bus.ctrl_st), 8'h00);
        pop_check("ctrl_c");
        pop_check("ctrl_a");

        // Nine spaces into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            send(8'h29);
            if (i < 8) exp_q.push_back(8'h20);
        end
        check("overflow_set", 8'(bus.overflow), 8'h01);
        check("full_head", bus.key_ascii, exp_q[0]);
        bus.scan_data  = 8'h0D;
        bus.scan_valid = 1'b1;
        bus.key_rd     = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.key_rd     = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h09);
        check("overflow_sticky", 8'(bus.overflow), 8'h01);
        for (int i = 0; i < 8; i++) pop_check("full_drain");
        expect_empty("full_drained");
        check("overflow_still", 8'(bus.overflow), 8'h01);

        // Reset mid-stream with a held Shift, a queued entry and a pending E0.
        send(8'h12);
        make(8'h29, 8'h20);
        send(8'hE0);
        check("pre_reset_valid", 8'(bus.key_valid), 8'h01);
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        expect_empty("async_reset");
        check("async_reset_shift", 8'(bus.shift_st), 8'h00);
        check("async_reset_ovf",   8'(bus.overflow), 8'h00);
        exp_q.delete();
        @(negedge clk);
        clr_n = 1'b1;
        make(8'h1C, 8'h61);
        pop_check("post_reset_a");
        expect_empty("post_reset_empty");

        // Extended cursor key.
        send(8'hE0);
        send(8'h75);
`ifdef PS2_EXT_KEYS_EN
        exp_q.push_back(8'h80);
        pop_check("ext_up");
`else
        expect_empty("ext_up_discarded");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
